// File: rtl/exec_result_queue.sv
// exec_result_queue
//
// Buffers completed micro-ops from the ALU and LSU execution lanes and hands
// exactly one result (or an all-zero bubble) per cycle to the retire stage.
// Retire never back-pressures, so this block does all stalling toward the
// lanes through the per-lane ready outputs.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   alu_valid_in        ALU lane has a result
//   alu_value_in        ALU result value
//   alu_comp_result_in  ALU comparison result
//   alu_op_in           ALU micro-op cell (bit 0 is optype[0], 0 = no op)
//   alu_ready_out       queue accepts from the ALU lane this cycle
//   lsu_*               same set for the LSU lane
//   value_out           registered result value to retire
//   comp_result_out     registered comparison result to retire
//   op_out              registered micro-op cell to retire (all-zero = bubble)
//   count_out           current occupancy
//   full_out            occupancy equals DEPTH
//   empty_out           occupancy equals zero

module exec_result_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int OP_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alu_valid_in,
    input  logic [DATA_W-1:0]          alu_value_in,
    input  logic                       alu_comp_result_in,
    input  logic [OP_W-1:0]            alu_op_in,
    output logic                       alu_ready_out,

    input  logic                       lsu_valid_in,
    input  logic [DATA_W-1:0]          lsu_value_in,
    input  logic                       lsu_comp_result_in,
    input  logic [OP_W-1:0]            lsu_op_in,
    output logic                       lsu_ready_out,

    output logic [DATA_W-1:0]          value_out,
    output logic                       comp_result_out,
    output logic [OP_W-1:0]            op_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       full_out,
    output logic                       empty_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = DATA_W + 1 + OP_W;

    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] headPtr_q, headPtr_d;
    logic [PW-1:0] tailPtr_q, tailPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_q, rr_d;
    logic [EW-1:0] out_q, out_d;

    logic          freeTwoPlus;
    logic          freeOne;
    logic          aluReady;
    logic          lsuReady;
    logic          aluPush;
    logic          lsuPush;
    logic          pop;
    logic [PW-1:0] lsuSlot;
    logic [EW-1:0] aluEntry;
    logic [EW-1:0] lsuEntry;

    // Pointer increment with an explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign aluEntry = {alu_value_in, alu_comp_result_in, alu_op_in};
    assign lsuEntry = {lsu_value_in, lsu_comp_result_in, lsu_op_in};

    // Ready depends only on occupancy and the round-robin bit, never on valid,
    // so there is no combinational valid-to-ready path. With a single free
    // slot only the favoured lane is offered it.
    always_comb begin
        freeTwoPlus = (count_q <= CW'(DEPTH - 2));
        freeOne     = (count_q == CW'(DEPTH - 1));
        aluReady    = freeTwoPlus | (freeOne & ~rr_q);
        lsuReady    = freeTwoPlus | (freeOne & rr_q);
    end

    assign alu_ready_out = aluReady;
    assign lsu_ready_out = lsuReady;

    // Next-state logic. On a double push the ALU entry goes first so the LSU
    // entry lands one slot further on. The pop decision uses the occupancy
    // before the edge, so a pop never frees a slot for pushes in the same
    // cycle. An empty queue loads the all-zero bubble into the outputs.
    always_comb begin
        aluPush   = alu_valid_in & aluReady;
        lsuPush   = lsu_valid_in & lsuReady;
        pop       = (count_q != '0);
        lsuSlot   = aluPush ? incPtr(tailPtr_q) : tailPtr_q;

        tailPtr_d = tailPtr_q;
        if (aluPush && lsuPush) begin
            tailPtr_d = incPtr(incPtr(tailPtr_q));
        end else if (aluPush || lsuPush) begin
            tailPtr_d = incPtr(tailPtr_q);
        end

        headPtr_d = pop ? incPtr(headPtr_q) : headPtr_q;
        out_d     = pop ? mem[headPtr_q] : '0;
        count_d   = count_q + CW'(aluPush) + CW'(lsuPush) - CW'(pop);
        rr_d      = (freeOne && (aluPush || lsuPush)) ? ~rr_q : rr_q;
    end

    // Control and output registers. Reset empties the queue, favours the ALU
    // and forces a bubble onto the retire interface immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            rr_q      <= 1'b0;
            out_q     <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            out_q     <= out_d;
        end
    end

    // Entry storage. Contents need no reset because occupancy gates every
    // read; write slots are always free slots, so they never collide with
    // the entry being popped.
    always_ff @(posedge clk) begin
        if (aluPush) begin
            mem[tailPtr_q] <= aluEntry;
        end
        if (lsuPush) begin
            mem[lsuSlot] <= lsuEntry;
        end
    end

    assign {value_out, comp_result_out, op_out} = out_q;
    assign count_out = count_q;
    assign full_out  = (count_q == CW'(DEPTH));
    assign empty_out = (count_q == '0);

    // Occupancy can never exceed the storage size.
    countBound: assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_exec_result_queue.sv
// tb_exec_result_queue
//
// Bench for exec_result_queue. The reference model is a plain queue of
// entries plus a round-robin bit: each cycle it pops the oldest entry into
// the expected output and appends the accepted lane entries (ALU first).
// Op cells use op[15:8] as rob_addr and op[0] as optype[0].

module tb_exec_result_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int OP_W   = 16;
    localparam int EW     = DATA_W + 1 + OP_W;

    typedef logic [EW-1:0] ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid_in;
    logic [DATA_W-1:0] alu_value_in;
    logic              alu_comp_result_in;
    logic [OP_W-1:0]   alu_op_in;
    logic              alu_ready_out;
    logic              lsu_valid_in;
    logic [DATA_W-1:0] lsu_value_in;
    logic              lsu_comp_result_in;
    logic [OP_W-1:0]   lsu_op_in;
    logic              lsu_ready_out;
    logic [DATA_W-1:0] value_out;
    logic              comp_result_out;
    logic [OP_W-1:0]   op_out;
    logic [3:0]        count_out;
    logic              full_out;
    logic              empty_out;

    ent_t mq[$];
    ent_t expOut;
    bit   mRr;
    bit   aluHeld;
    bit   lsuHeld;
    int   nCompared = 0;
    int   nMismatch = 0;

    exec_result_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_valid_in       (alu_valid_in),
        .alu_value_in       (alu_value_in),
        .alu_comp_result_in (alu_comp_result_in),
        .alu_op_in          (alu_op_in),
        .alu_ready_out      (alu_ready_out),
        .lsu_valid_in       (lsu_valid_in),
        .lsu_value_in       (lsu_value_in),
        .lsu_comp_result_in (lsu_comp_result_in),
        .lsu_op_in          (lsu_op_in),
        .lsu_ready_out      (lsu_ready_out),
        .value_out          (value_out),
        .comp_result_out    (comp_result_out),
        .op_out             (op_out),
        .count_out          (count_out),
        .full_out           (full_out),
        .empty_out          (empty_out)
    );

    // Free-running clock; the bench works on falling edges only.
    always #5 clk = ~clk;

    function automatic ent_t randEnt();
        return {32'($urandom), 1'($urandom_range(0, 1)), 16'($urandom)};
    endfunction

    // Model ready rule: two or more free slots open both lanes, one free slot
    // opens only the favoured lane, none opens neither.
    function automatic bit modelReady(input bit isLsu);
        int freeSlots;
        freeSlots = DEPTH - mq.size();
        if (freeSlots >= 2) return 1'b1;
        if (freeSlots == 1) return isLsu ? mRr : !mRr;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mq.delete();
        expOut       = '0;
        mRr          = 1'b0;
        aluHeld      = 1'b0;
        lsuHeld      = 1'b0;
        alu_valid_in = 1'b0;
        lsu_valid_in = 1'b0;
    endtask

    // Drives one cycle from a falling edge to the next. A lane that was left
    // waiting keeps its valid and data; otherwise it offers the given entry.
    // The model advances by the rising edge in between.
    task automatic applyStimulus(input bit aluNew, input ent_t aluEnt,
                                 input bit lsuNew, input ent_t lsuEnt);
        bit   aluTx;
        bit   lsuTx;
        int   freeSlots;
        ent_t nextOut;
        if (!aluHeld) begin
            alu_valid_in = aluNew;
            {alu_value_in, alu_comp_result_in, alu_op_in} = aluEnt;
        end
        if (!lsuHeld) begin
            lsu_valid_in = lsuNew;
            {lsu_value_in, lsu_comp_result_in, lsu_op_in} = lsuEnt;
        end
        freeSlots = DEPTH - mq.size();
        aluTx = alu_valid_in && modelReady(1'b0);
        lsuTx = lsu_valid_in && modelReady(1'b1);
        nextOut = '0;
        if (mq.size() > 0) nextOut = mq.pop_front();
        if (aluTx) mq.push_back({alu_value_in, alu_comp_result_in, alu_op_in});
        if (lsuTx) mq.push_back({lsu_value_in, lsu_comp_result_in, lsu_op_in});
        if (freeSlots == 1 && (aluTx || lsuTx)) mRr = !mRr;
        aluHeld = alu_valid_in && !aluTx;
        lsuHeld = lsu_valid_in && !lsuTx;
        expOut  = nextOut;
        @(negedge clk);
    endtask

    // Reset held for three cycles, then five idle cycles of bubbles.
    task automatic test_reset();
        rst = 1'b0;
        modelReset();
        alu_value_in = '0; alu_comp_result_in = 1'b0; alu_op_in = '0;
        lsu_value_in = '0; lsu_comp_result_in = 1'b0; lsu_op_in = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nCompared++;
            if (count_out !== 4'd0 || empty_out !== 1'b1 || full_out !== 1'b0) begin
                nMismatch++;
                $display("[TB] FAIL reset_flags[%0d]: got count=%0d empty=%b full=%b want 0/1/0", i, count_out, empty_out, full_out);
            end
            nCompared++;
            if ({value_out, comp_result_out, op_out} !== '0) begin
                nMismatch++;
                $display("[TB] FAIL reset_out[%0d]: got %h want 0", i, {value_out, comp_result_out, op_out});
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0);
            nCompared++;
            if (op_out !== '0 || empty_out !== 1'b1) begin
                nMismatch++;
                $display("[TB] FAIL idle_out[%0d]: got op=%h empty=%b want 0/1", i, op_out, empty_out);
            end
            nCompared++;
            if (alu_ready_out !== 1'b1 || lsu_ready_out !== 1'b1) begin
                nMismatch++;
                $display("[TB] FAIL idle_ready[%0d]: got alu=%b lsu=%b want 1/1", i, alu_ready_out, lsu_ready_out);
            end
        end
    endtask

    // One ALU push appears one edge after acceptance, for a single cycle.
    task automatic test_single_push();
        ent_t ent;
        ent = {32'h0000_1234, 1'b0, 16'h0501};
        applyStimulus(1'b1, ent, 1'b0, '0);
        nCompared++;
        if (count_out !== 4'd1 || op_out !== '0) begin
            nMismatch++;
            $display("[TB] FAIL single_edgeE: got count=%0d op=%h want 1/0", count_out, op_out);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        nCompared++;
        if (value_out !== 32'h1234 || op_out[15:8] !== 8'd5 || op_out[0] !== 1'b1 || count_out !== 4'd0) begin
            nMismatch++;
            $display("[TB] FAIL single_edgeE1: got value=%h rob=%0d opt0=%b count=%0d want 1234/5/1/0", value_out, op_out[15:8], op_out[0], count_out);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        nCompared++;
        if (value_out !== '0 || op_out !== '0) begin
            nMismatch++;
            $display("[TB] FAIL single_bubble: got value=%h op=%h want 0/0", value_out, op_out);
        end
    endtask

    // Three double pushes; output order alternates ALU/LSU per cycle.
    task automatic test_ordering();
        ent_t ordr[6];
        ent_t a;
        ent_t l;
        for (int step = 1; step <= 8; step++) begin
            if (step <= 3) begin
                a = randEnt();
                l = randEnt();
                ordr[2*(step-1)]   = a;
                ordr[2*(step-1)+1] = l;
                applyStimulus(1'b1, a, 1'b1, l);
                nCompared++;
                if (count_out !== 4'(step + 1)) begin
                    nMismatch++;
                    $display("[TB] FAIL order_count[%0d]: got %0d want %0d", step, count_out, step + 1);
                end
            end else begin
                applyStimulus(1'b0, '0, 1'b0, '0);
            end
            if (step >= 2 && step <= 7) begin
                nCompared++;
                if ({value_out, comp_result_out, op_out} !== ordr[step-2]) begin
                    nMismatch++;
                    $display("[TB] FAIL order_out[%0d]: got %h want %h", step - 2, {value_out, comp_result_out, op_out}, ordr[step-2]);
                end
            end
        end
        nCompared++;
        if (op_out !== '0 || empty_out !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL order_drained: got op=%h empty=%b want 0/1", op_out, empty_out);
        end
    endtask

    // Both lanes valid from empty: occupancy climbs to DEPTH-1, where the
    // single free slot alternates between the lanes starting with the ALU.
    task automatic test_fill();
        int expCnt;
        bit expAlu;
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expCnt = (i == 0) ? 0 : ((i < 6) ? i + 1 : 7);
            expAlu = (i < 6) ? 1'b1 : ((i - 6) % 2 == 0);
            nCompared++;
            if (count_out !== 4'(expCnt) || full_out !== 1'b0) begin
                nMismatch++;
                $display("[TB] FAIL fill_count[%0d]: got %0d full=%b want %0d/0", i, count_out, full_out, expCnt);
            end
            nCompared++;
            if (alu_ready_out !== expAlu || lsu_ready_out !== ((i < 6) ? 1'b1 : !expAlu)) begin
                nMismatch++;
                $display("[TB] FAIL fill_ready[%0d]: got alu=%b lsu=%b want alu=%b", i, alu_ready_out, lsu_ready_out, expAlu);
            end
            applyStimulus(1'b1, randEnt(), 1'b1, randEnt());
            nCompared++;
            if ({value_out, comp_result_out, op_out} !== expOut) begin
                nMismatch++;
                $display("[TB] FAIL fill_out[%0d]: got %h want %h", i, {value_out, comp_result_out, op_out}, expOut);
            end
        end
    endtask

    // LSU offers a marker while not ready; it must come out exactly once.
    task automatic test_stall_hold();
        ent_t marker;
        int   seen;
        marker = {32'hDEAD_BEEF, 1'b1, 16'hABCD};
        seen   = 0;
        nCompared++;
        if (lsu_ready_out !== 1'b0 || alu_ready_out !== 1'b1) begin
            nMismatch++;
            $display("[TB] FAIL stall_ready: got alu=%b lsu=%b want 1/0", alu_ready_out, lsu_ready_out);
        end
        for (int i = 0; i < 18; i++) begin
            applyStimulus(i < 4, randEnt(), i == 0, marker);
            if ({value_out, comp_result_out, op_out} === marker) seen++;
            nCompared++;
            if ({value_out, comp_result_out, op_out} !== expOut) begin
                nMismatch++;
                $display("[TB] FAIL stall_out[%0d]: got %h want %h", i, {value_out, comp_result_out, op_out}, expOut);
            end
        end
        nCompared++;
        if (seen !== 1) begin
            nMismatch++;
            $display("[TB] FAIL stall_once: got %0d deliveries want 1", seen);
        end
        nCompared++;
        if (count_out !== 4'd0) begin
            nMismatch++;
            $display("[TB] FAIL stall_drain: got count=%0d want 0", count_out);
        end
    endtask

    // Reset dropped between edges with five entries queued.
    task automatic test_async_reset();
        ent_t x;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randEnt(), 1'b1, randEnt());
        nCompared++;
        if (count_out !== 4'd5) begin
            nMismatch++;
            $display("[TB] FAIL areset_pre: got count=%0d want 5", count_out);
        end
        #2 rst = 1'b0;
        #1;
        nCompared++;
        if (count_out !== 4'd0 || empty_out !== 1'b1 || {value_out, comp_result_out, op_out} !== '0) begin
            nMismatch++;
            $display("[TB] FAIL areset_now: got count=%0d empty=%b out=%h want 0/1/0", count_out, empty_out, {value_out, comp_result_out, op_out});
        end
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        x = randEnt();
        applyStimulus(1'b1, x, 1'b0, '0);
        nCompared++;
        if (op_out !== '0 || count_out !== 4'd1) begin
            nMismatch++;
            $display("[TB] FAIL areset_edge1: got op=%h count=%0d want 0/1", op_out, count_out);
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        nCompared++;
        if ({value_out, comp_result_out, op_out} !== x) begin
            nMismatch++;
            $display("[TB] FAIL areset_edge2: got %h want %h", {value_out, comp_result_out, op_out}, x);
        end
    endtask

    // Random lane traffic against the queue model.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            nCompared++;
            if (alu_ready_out !== modelReady(1'b0) || lsu_ready_out !== modelReady(1'b1)) begin
                nMismatch++;
                $display("[TB] FAIL rand_ready[%0d]: got alu=%b lsu=%b want alu=%b lsu=%b", i, alu_ready_out, lsu_ready_out, modelReady(1'b0), modelReady(1'b1));
            end
            applyStimulus($urandom_range(0, 9) < 8, randEnt(), $urandom_range(0, 9) < 7, randEnt());
            nCompared++;
            if ({value_out, comp_result_out, op_out} !== expOut) begin
                nMismatch++;
                $display("[TB] FAIL rand_out[%0d]: got %h want %h", i, {value_out, comp_result_out, op_out}, expOut);
            end
            nCompared++;
            if (int'(count_out) != mq.size() || empty_out !== (mq.size() == 0) || full_out !== (mq.size() == DEPTH)) begin
                nMismatch++;
                $display("[TB] FAIL rand_count[%0d]: got %0d empty=%b full=%b want %0d", i, count_out, empty_out, full_out, mq.size());
            end
        end
    endtask

    // Scenario sequence followed by the one-line summary.
    initial begin
        test_reset();
        test_single_push();
        test_ordering();
        test_fill();
        test_stall_hold();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
